// File: rtl/dp_ram_stream_pkg.sv
// Shared types and helpers for the dual-port RAM burst stream reader.
package dp_ram_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  // A command is illegal if it starts outside the RAM or asks for more words than exist.
  function automatic logic cmd_reject(input int unsigned addr,
                                      input int unsigned len,
                                      input int unsigned depth);
    return (addr >= depth) || (len > depth);
  endfunction

endpackage

// File: rtl/dp_ram_stream_reader.sv
// Reads bursts from an asynchronous-read RAM and presents them as a valid/ready stream.
module dp_ram_stream_reader
  import dp_ram_stream_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  CmdValid_SI,
  output logic                  CmdReady_SO,
  input  logic [ADDR_WIDTH-1:0] CmdAddr_DI,
  input  logic [LEN_WIDTH-1:0]  CmdLen_DI,
  output logic [ADDR_WIDTH-1:0] RamRdAddr_DO,
  input  logic [DATA_WIDTH-1:0] RamRdData_DI,
  output logic                  OutValid_SO,
  input  logic                  OutReady_SI,
  output logic [DATA_WIDTH-1:0] OutData_DO,
  output logic                  OutLast_SO,
  output logic                  Done_SO,
  output logic                  Err_SO
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (CmdValid_SI) begin
          if (cmd_reject(32'(CmdAddr_DI), 32'(CmdLen_DI), DATA_DEPTH)) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            addr_d = CmdAddr_DI;
            rem_d  = CmdLen_DI;
            if (CmdLen_DI == '0) done_d  = 1'b1;
            else                 state_d = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        // A new beat replaces the output register whenever it is empty or being consumed.
        if (!valid_q || OutReady_SI) begin
          data_d  = RamRdData_DI;
          valid_d = 1'b1;
          addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          rem_d   = rem_q - LEN_ONE;
          last_d  = (rem_q == LEN_ONE);
          if (rem_q == LEN_ONE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (OutReady_SI) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign CmdReady_SO  = (state_q == ST_IDLE);
  assign RamRdAddr_DO = addr_q;
  assign OutValid_SO  = valid_q;
  assign OutData_DO   = data_q;
  assign OutLast_SO   = last_q;
  assign Done_SO      = done_q;
  assign Err_SO       = err_q;

`ifndef SYNTHESIS
  a_depth_fits: assert property (@(posedge Clk_CI) DATA_DEPTH <= (1 << ADDR_WIDTH))
    else $error("DATA_DEPTH exceeds 2**ADDR_WIDTH");

  a_stall_stable: assert property (@(posedge Clk_CI) disable iff (Rst_RI)
    (OutValid_SO && !OutReady_SI) |=>
      (OutValid_SO && $stable(OutData_DO) && $stable(OutLast_SO)))
    else $error("stream beat changed while stalled");
`endif

endmodule
